// File: rtl/mem_port_arbiter_if.sv
// Bus bundle joining the two requesters and the shared single-port memory to mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic              owner;
  logic              busy;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, owner, busy, mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, owner, busy, mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of a single-port memory.
// Each transaction runs IDLE -> ACCESS -> ACK; the memory acts on the negedge inside ACCESS.
module mem_port_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t            state, state_nxt;
  logic              owner;
  logic              lock_valid;
  logic [3:0]        burst_cnt;
  logic              txn_we;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  logic [DATA_W-1:0] read_data;

  logic req_own, req_oth, lock_own, lock_eff;
  logic grant, winner;
  logic ack0, ack1, busy, mem_cs, mem_we;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A lock only counts while the current owner still asserts it.
  always_comb begin
    req_own   = owner ? bus.req1 : bus.req0;
    req_oth   = owner ? bus.req0 : bus.req1;
    lock_own  = owner ? bus.lock1 : bus.lock0;
    lock_eff  = lock_valid & lock_own;
    grant     = 1'b0;
    winner    = owner;
    state_nxt = state;
    if (lock_eff) begin
      if (burst_cnt < MAX_CNT) begin
        grant = req_own;
      end else if (req_oth) begin
        grant  = 1'b1;
        winner = ~owner;
      end else begin
        grant = req_own;
      end
    end else if (bus.req0 & bus.req1) begin
      grant  = 1'b1;
      winner = ~owner;
    end else if (bus.req0 | bus.req1) begin
      grant  = 1'b1;
      winner = bus.req1;
    end
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack0   = (state == ACK) & ~owner;
    ack1   = (state == ACK) & owner;
    busy   = (state != IDLE);
    mem_cs = (state == ACCESS);
    mem_we = (state == ACCESS) & txn_we;
  end

  // Burst count restarts at 1 on any handoff or when a saturated lock re-grants its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b1;
      lock_valid <= 1'b0;
      burst_cnt  <= 4'd0;
    end else if (state == IDLE) begin
      if (grant) begin
        owner      <= winner;
        lock_valid <= winner ? bus.lock1 : bus.lock0;
        burst_cnt  <= (lock_eff && (winner == owner) && (burst_cnt < MAX_CNT)) ?
                      burst_cnt + 4'd1 : 4'd1;
      end else begin
        lock_valid <= lock_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_we    <= 1'b0;
      txn_addr  <= '0;
      txn_wdata <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && grant) begin
        txn_we    <= winner ? bus.we1 : bus.we0;
        txn_addr  <= winner ? bus.addr1 : bus.addr0;
        txn_wdata <= winner ? bus.wdata1 : bus.wdata0;
      end
      if (state == ACCESS && !txn_we) read_data <= bus.mem_rdata;
    end
  end

  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.busy      = busy;
  assign bus.owner     = owner;
  assign bus.mem_cs    = mem_cs;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = txn_addr;
  assign bus.mem_wdata = txn_wdata;
  assign bus.rdata     = read_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Environment memory: acts on the negedge like the real part.
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  logic              init_en = 1'b0;
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0F0F;
  endfunction

  always @(negedge clk) begin
    if (init_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end
    if (bus.mem_cs) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Reference model state (transaction phase: 0 free, 1 memory access, 2 acknowledge).
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                m_phase;
  int                m_cnt;
  logic              m_owner, m_lv, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_init();
    init_en = 1'b1;
    @(negedge clk);
    #1;
    init_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic l,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic idle_ports();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulse_reset();
    idle_ports();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_owner = 1'b1; m_lv = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  // Advances the model by one clock using the inputs currently presented.
  task automatic model_step();
    logic [1:0] req, lk;
    logic       held, w;
    bit         g;
    req = {bus.req1, bus.req0};
    lk  = {bus.lock1, bus.lock0};
    if (m_phase == 0) begin
      held = m_lv && lk[m_owner];
      g = 1'b0;
      w = m_owner;
      if (held && m_cnt < MAX_BURST) begin
        g = req[m_owner];
      end else if (held && req[!m_owner]) begin
        g = 1'b1; w = !m_owner;
      end else if (held) begin
        g = req[m_owner];
      end else if (req == 2'b11) begin
        g = 1'b1; w = !m_owner;
      end else if (req != 2'b00) begin
        g = 1'b1; w = req[1];
      end
      if (g) begin
        m_cnt   = (held && w == m_owner && m_cnt < MAX_BURST) ? m_cnt + 1 : 1;
        m_owner = w;
        m_lv    = lk[w];
        m_we    = w ? bus.we1 : bus.we0;
        m_addr  = w ? bus.addr1 : bus.addr0;
        m_wdata = w ? bus.wdata1 : bus.wdata0;
        m_phase = 1;
      end else begin
        m_lv = held;
      end
    end else if (m_phase == 1) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rdata = ref_mem[m_addr];
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic test_reset();
    idle_ports();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({bus.ack0, bus.ack1, bus.mem_cs, bus.mem_we, bus.busy} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctl: got %b expected 00000", {bus.ack0, bus.ack1, bus.mem_cs, bus.mem_we, bus.busy});
    end
    n_checks++;
    if (bus.owner !== 1'b1) begin
      n_errors++; $display("FAIL reset_owner: got %b expected 1", bus.owner);
    end
    n_checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.rdata !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected all 0", bus.mem_addr, bus.mem_wdata, bus.rdata);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mem_cs !== 1'b0) begin
      n_errors++; $display("FAIL reset_idle: got busy=%b cs=%b expected 0 0", bus.busy, bus.mem_cs);
    end
  endtask

  task automatic test_single_read();
    preload(7'd5, 32'hDEADBEEF);
    set_port(0, 1'b1, 1'b0, 1'b0, 7'd5, '0);
    tick();
    n_checks++;
    if ({bus.mem_cs, bus.mem_we, bus.busy, bus.ack0} !== 4'b1010 || bus.mem_addr !== 7'd5) begin
      n_errors++;
      $display("FAIL read_access: got cs/we/busy/ack0=%b addr=%0d expected 1010 addr=5",
               {bus.mem_cs, bus.mem_we, bus.busy, bus.ack0}, bus.mem_addr);
    end
    tick();
    n_checks++;
    if ({bus.ack0, bus.ack1, bus.mem_cs} !== 3'b100 || bus.owner !== 1'b0) begin
      n_errors++;
      $display("FAIL read_ack: got ack0/ack1/cs=%b owner=%b expected 100 owner=0", {bus.ack0, bus.ack1, bus.mem_cs}, bus.owner);
    end
    n_checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL read_data: got %h expected deadbeef", bus.rdata);
    end
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    n_checks++;
    if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL read_done: got ack0=%b busy=%b expected 0 0", bus.ack0, bus.busy);
    end
  endtask

  task automatic test_write_read();
    set_port(1, 1'b1, 1'b1, 1'b0, 7'd7, 32'h12345678);
    tick();
    n_checks++;
    if ({bus.mem_cs, bus.mem_we} !== 2'b11 || bus.mem_addr !== 7'd7 || bus.mem_wdata !== 32'h12345678) begin
      n_errors++;
      $display("FAIL write_access: got cs/we=%b addr=%0d wdata=%h expected 11 7 12345678",
               {bus.mem_cs, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    n_checks++;
    if ({bus.ack1, bus.ack0, bus.mem_we, bus.mem_cs} !== 4'b1000 || bus.owner !== 1'b1) begin
      n_errors++;
      $display("FAIL write_ack: got ack1/ack0/we/cs=%b owner=%b expected 1000 owner=1",
               {bus.ack1, bus.ack0, bus.mem_we, bus.mem_cs}, bus.owner);
    end
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.ack1 !== 1'b0) begin
      n_errors++; $display("FAIL write_idle: got we=%b ack1=%b expected 0 0", bus.mem_we, bus.ack1);
    end
    set_port(0, 1'b1, 1'b0, 1'b0, 7'd7, '0);
    tick();
    n_checks++;
    if ({bus.mem_cs, bus.mem_we} !== 2'b10) begin
      n_errors++; $display("FAIL readback_access: got cs/we=%b expected 10", {bus.mem_cs, bus.mem_we});
    end
    tick();
    n_checks++;
    if (bus.ack0 !== 1'b1 || bus.rdata !== 32'h12345678) begin
      n_errors++; $display("FAIL readback_data: got ack0=%b rdata=%h expected 1 12345678", bus.ack0, bus.rdata);
    end
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_round_robin();
    int   n, last;
    int   last_p [2];
    logic port;
    pulse_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 7'd1, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, 7'd2, '0);
    n = 0; last = -1; last_p[0] = 0; last_p[1] = 0;
    for (int cyc = 1; cyc <= 40 && n < 8; cyc++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        port = bus.ack1;
        n_checks++;
        if (bus.ack0 && bus.ack1) begin
          n_errors++; $display("FAIL rr_double_ack: got both acks at cycle %0d expected one", cyc);
        end
        n_checks++;
        if (port !== 1'(n % 2) || cyc - last != 3) begin
          n_errors++;
          $display("FAIL rr_order: ack %0d got port %b after %0d cycles expected port %0d after 3", n, port, cyc - last, n % 2);
        end
        n_checks++;
        if (cyc - last_p[port] > 6) begin
          n_errors++; $display("FAIL rr_wait: port %b waited %0d cycles expected at most 6", port, cyc - last_p[port]);
        end
        last = cyc;
        last_p[port] = cyc;
        n++;
        if (n == 8) idle_ports();
      end
    end
    n_checks++;
    if (n != 8) begin
      n_errors++; $display("FAIL rr_timeout: got %0d acks expected 8", n);
    end
    idle_ports();
    tick();
    tick();
  endtask

  task automatic test_lock_burst();
    bit   exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int   n;
    logic port;
    pulse_reset();
    set_port(0, 1'b1, 1'b0, 1'b1, 7'd3, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, 7'd4, '0);
    n = 0;
    for (int cyc = 1; cyc <= 60 && n < 10; cyc++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        port = bus.ack1;
        n_checks++;
        if (port !== exp_seq[n] || (bus.ack0 && bus.ack1)) begin
          n_errors++;
          $display("FAIL lock_burst: grant %0d got ack0/ack1=%b%b expected port %0d", n, bus.ack0, bus.ack1, exp_seq[n]);
        end
        n++;
        if (n == 10) idle_ports();
      end
    end
    n_checks++;
    if (n != 10) begin
      n_errors++; $display("FAIL lock_burst_timeout: got %0d acks expected 10", n);
    end
    idle_ports();
    tick();
    tick();
  endtask

  task automatic test_lock_drop();
    bit   exp_seq [4] = '{0, 0, 1, 0};
    int   n;
    logic port;
    pulse_reset();
    set_port(0, 1'b1, 1'b0, 1'b1, 7'd3, '0);
    set_port(1, 1'b1, 1'b0, 1'b0, 7'd4, '0);
    n = 0;
    for (int cyc = 1; cyc <= 30 && n < 4; cyc++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        port = bus.ack1;
        n_checks++;
        if (port !== exp_seq[n]) begin
          n_errors++; $display("FAIL lock_drop: grant %0d got port %b expected %0d", n, port, exp_seq[n]);
        end
        n++;
        if (n == 2) bus.lock0 = 1'b0;
        if (n == 4) idle_ports();
      end
    end
    n_checks++;
    if (n != 4) begin
      n_errors++; $display("FAIL lock_drop_timeout: got %0d acks expected 4", n);
    end
    idle_ports();
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    idle_ports();
    tick();
    preload(7'd9, 32'hCAFEF00D);
    set_port(0, 1'b1, 1'b0, 1'b0, 7'd3, '0);
    tick();
    n_checks++;
    if (bus.mem_cs !== 1'b1) begin
      n_errors++; $display("FAIL abort_setup: got cs=%b expected 1", bus.mem_cs);
    end
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    n_checks++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.mem_cs, bus.mem_we} !== 5'b0 || bus.mem_addr !== '0 ||
        bus.rdata !== '0 || bus.owner !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_reset: got ctl=%b addr=%h rdata=%h owner=%b expected 00000 0 0 1",
               {bus.ack0, bus.ack1, bus.busy, bus.mem_cs, bus.mem_we}, bus.mem_addr, bus.rdata, bus.owner);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_no_ack: got ack0=%b busy=%b expected 0 0", bus.ack0, bus.busy);
    end
    set_port(1, 1'b1, 1'b0, 1'b0, 7'd9, '0);
    tick();
    tick();
    n_checks++;
    if (bus.ack1 !== 1'b1 || bus.rdata !== 32'hCAFEF00D) begin
      n_errors++; $display("FAIL abort_recover: got ack1=%b rdata=%h expected 1 cafef00d", bus.ack1, bus.rdata);
    end
    idle_ports();
    tick();
  endtask

  task automatic test_random();
    logic [5:0] exp_ctl;
    logic       r;
    mem_init();
    pulse_reset();
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      exp_ctl = {m_phase == 2 && !m_owner, m_phase == 2 && m_owner, m_phase != 0,
                 m_phase == 1, m_phase == 1 && m_we, m_owner};
      n_checks++;
      if ({bus.ack0, bus.ack1, bus.busy, bus.mem_cs, bus.mem_we, bus.owner} !== exp_ctl) begin
        n_errors++;
        $display("FAIL rand_ctl: cycle %0d got ack0/ack1/busy/cs/we/owner=%b expected %b", cyc,
                 {bus.ack0, bus.ack1, bus.busy, bus.mem_cs, bus.mem_we, bus.owner}, exp_ctl);
      end
      n_checks++;
      if (bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata || bus.rdata !== m_rdata) begin
        n_errors++;
        $display("FAIL rand_data: cycle %0d got addr=%h wdata=%h rdata=%h expected %h %h %h", cyc,
                 bus.mem_addr, bus.mem_wdata, bus.rdata, m_addr, m_wdata, m_rdata);
      end
      for (int p = 0; p < 2; p++) begin
        r = p ? bus.req1 : bus.req0;
        if (r && m_phase == 2 && m_owner == 1'(p)) begin
          if ($urandom_range(3) == 0)
            set_port(p, 1'b1, 1'($urandom_range(1)), ($urandom_range(3) == 0),
                     ADDR_W'($urandom_range(15)), $urandom());
          else
            set_port(p, 1'b0, 1'b0, 1'($urandom_range(1)), '0, '0);
        end else if (!r) begin
          if ($urandom_range(2) == 0)
            set_port(p, 1'b1, 1'($urandom_range(1)), ($urandom_range(3) == 0),
                     ADDR_W'($urandom_range(15)), $urandom());
          else
            set_port(p, 1'b0, 1'b0, 1'($urandom_range(1)), '0, '0);
        end
      end
      model_step();
      tick();
    end
    idle_ports();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_lock_burst();
    test_lock_drop();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
